mux_arb: RTL and testbench

MUX_ARB -- requirements
Module: mux_arb

---
 rtl/mux_arb.sv | 133 +++++++++++++
 tb/tb_mux_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb.sv
// Two-input wormhole packet arbiter feeding a registered 2:1 output stage.
// A HEAD flit locks the output to its port until that packet's TAIL is transferred.
module mux_arb #(
  parameter int unsigned DATAW = 66,
  parameter int unsigned VCHW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] idata_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_0,
  input  logic             ivalid_1,
  input  logic [VCHW-1:0]  ivch_0,
  input  logic [VCHW-1:0]  ivch_1,
  output logic             iack_0,
  output logic             iack_1,
  input  logic             oready,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCHW-1:0]  ovch,
  output logic             sel,
  output logic [15:0]      pkt_cnt_0,
  output logic [15:0]      pkt_cnt_1
);

  localparam logic [1:0] FlitHead = 2'b01;
  localparam logic [1:0] FlitTail = 2'b10;

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e           r_state;
  logic             r_prio;
  logic             r_sel;
  logic             r_ovalid;
  logic [DATAW-1:0] r_odata;
  logic [VCHW-1:0]  r_ovch;
  logic [15:0]      r_pkt_cnt_0;
  logic [15:0]      r_pkt_cnt_1;

  logic             w_head_0;
  logic             w_head_1;
  logic             w_ack_0;
  logic             w_ack_1;
  logic             w_ack;
  logic             w_mux_sel;
  logic             w_tail;
  logic [DATAW-1:0] w_mux_data;
  logic [VCHW-1:0]  w_mux_vch;

  assign w_head_0 = ivalid_0 && (idata_0[DATAW-1 -: 2] == FlitHead);
  assign w_head_1 = ivalid_1 && (idata_1[DATAW-1 -: 2] == FlitHead);

  // Only HEAD flits compete in idle; once locked, the owner streams freely.
  always_comb begin
    w_ack_0 = 1'b0;
    w_ack_1 = 1'b0;
    if (!rst && oready) begin
      case (r_state)
        StIdle: begin
          if (w_head_0 && w_head_1) begin
            w_ack_0 = ~r_prio;
            w_ack_1 = r_prio;
          end else begin
            w_ack_0 = w_head_0;
            w_ack_1 = w_head_1;
          end
        end
        StLock0: w_ack_0 = ivalid_0;
        StLock1: w_ack_1 = ivalid_1;
        default: begin
          w_ack_0 = 1'b0;
          w_ack_1 = 1'b0;
        end
      endcase
    end
  end

  assign w_ack      = w_ack_0 | w_ack_1;
  assign w_mux_sel  = w_ack_1;
  assign w_mux_data = w_mux_sel ? idata_1 : idata_0;
  assign w_mux_vch  = w_mux_sel ? ivch_1 : ivch_0;
  assign w_tail     = (w_mux_data[DATAW-1 -: 2] == FlitTail);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_prio      <= 1'b0;
      r_sel       <= 1'b0;
      r_ovalid    <= 1'b0;
      r_odata     <= '0;
      r_ovch      <= '0;
      r_pkt_cnt_0 <= '0;
      r_pkt_cnt_1 <= '0;
    end else begin
      r_ovalid <= w_ack;
      if (w_ack) begin
        r_odata <= w_mux_data;
        r_ovch  <= w_mux_vch;
        r_sel   <= w_mux_sel;
      end
      case (r_state)
        StIdle: begin
          if (w_ack) r_state <= w_mux_sel ? StLock1 : StLock0;
        end
        StLock0: begin
          if (w_ack_0 && w_tail) begin
            r_state     <= StIdle;
            r_prio      <= 1'b1;
            r_pkt_cnt_0 <= r_pkt_cnt_0 + 16'd1;
          end
        end
        StLock1: begin
          if (w_ack_1 && w_tail) begin
            r_state     <= StIdle;
            r_prio      <= 1'b0;
            r_pkt_cnt_1 <= r_pkt_cnt_1 + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign iack_0    = w_ack_0;
  assign iack_1    = w_ack_1;
  assign odata     = r_odata;
  assign ovalid    = r_ovalid;
  assign ovch      = r_ovch;
  assign sel       = r_sel;
  assign pkt_cnt_0 = r_pkt_cnt_0;
  assign pkt_cnt_1 = r_pkt_cnt_1;

endmodule

// File: tb/tb_mux_arb.sv
// Randomised scoreboard bench for mux_arb: a packet-level model predicts acks and
// output flits; a negedge monitor pops expected flits whenever ovalid is seen.
module tb_mux_arb;
  localparam int unsigned DATAW = 66;
  localparam int unsigned VCHW  = 2;
  localparam int unsigned PW    = DATAW - 2;
  localparam logic [1:0] THead = 2'b01;
  localparam logic [1:0] TTail = 2'b10;
  localparam logic [1:0] TData = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic [DATAW-1:0] idata_0, idata_1, odata;
  logic             ivalid_0, ivalid_1, iack_0, iack_1, oready, ovalid, sel;
  logic [VCHW-1:0]  ivch_0, ivch_1, ovch;
  logic [15:0]      pkt_cnt_0, pkt_cnt_1;

  mux_arb #(.DATAW(DATAW), .VCHW(VCHW)) dut (
    .clk(clk), .rst(rst),
    .idata_0(idata_0), .idata_1(idata_1),
    .ivalid_0(ivalid_0), .ivalid_1(ivalid_1),
    .ivch_0(ivch_0), .ivch_1(ivch_1),
    .iack_0(iack_0), .iack_1(iack_1),
    .oready(oready), .odata(odata), .ovalid(ovalid), .ovch(ovch), .sel(sel),
    .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [DATAW-1:0] data; logic [VCHW-1:0] vch;} flit_t;
  typedef struct packed {logic [DATAW-1:0] data; logic [VCHW-1:0] vch; logic sel;} out_t;

  flit_t src0[$], src1[$];
  out_t  exp_q[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0, start0 = 0, start1 = 0, payload_seq = 0;

  // Reference model: which port owns the output (-1 = nobody) plus architectural outputs.
  int               m_lock = -1;
  bit               m_prio, m_sel, m_ovalid, m_known;
  logic [DATAW-1:0] m_odata;
  logic [VCHW-1:0]  m_ovch;
  int               m_cnt[2];

  int         ack_cyc[$];
  bit         ack_port[$];
  logic [1:0] ack_type[$];
  bit         grant_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    out_t e;
    if (ovalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_ovalid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_odata", odata, e.data);
        check("sb_ovch", ovch, e.vch);
        check("sb_sel", sel, e.sel);
      end
    end
  end

  task automatic add_pkt(input int port, input int ndata, input int mid_head);
    flit_t      f;
    logic [1:0] t;
    logic [VCHW-1:0] v;
    v = VCHW'($urandom);
    for (int i = 0; i < ndata + 2; i++) begin
      t = (i == 0) ? THead : (i == ndata + 1) ? TTail : (i == mid_head) ? THead : TData;
      payload_seq++;
      f.data = {t, PW'({$urandom(), payload_seq})};
      f.vch  = v;
      if (port == 0) src0.push_back(f);
      else src1.push_back(f);
    end
  endtask

  task automatic clear_log();
    ack_cyc.delete();
    ack_port.delete();
    ack_type.delete();
    grant_q.delete();
  endtask

  // One clock: entered and left at posedge+1.
  task automatic do_cycle(input bit rdy, input int bub_pct);
    bit         v0, v1, a0, a1, e0, e1, p;
    flit_t      f0, f1, f;
    logic [1:0] t;
    out_t       o;
    if (m_known) begin
      check("ovalid", ovalid, m_ovalid);
      check("odata_hold", odata, m_odata);
      check("ovch_hold", ovch, m_ovch);
      check("sel_hold", sel, m_sel);
      check("pkt_cnt_0", pkt_cnt_0, 16'(m_cnt[0]));
      check("pkt_cnt_1", pkt_cnt_1, 16'(m_cnt[1]));
    end
    v0 = (src0.size() > 0) && (cyc >= start0) && (int'($urandom_range(99)) >= bub_pct);
    v1 = (src1.size() > 0) && (cyc >= start1) && (int'($urandom_range(99)) >= bub_pct);
    f0 = v0 ? src0[0] : flit_t'({$urandom(), $urandom(), $urandom()});
    f1 = v1 ? src1[0] : flit_t'({$urandom(), $urandom(), $urandom()});
    ivalid_0 = v0; idata_0 = f0.data; ivch_0 = f0.vch;
    ivalid_1 = v1; idata_1 = f1.data; ivch_1 = f1.vch;
    oready = rdy;
    #3;
    a0 = 1'b0;
    a1 = 1'b0;
    if (!rst && rdy) begin
      if (m_lock < 0) begin
        e0 = v0 && (f0.data[DATAW-1 -: 2] == THead);
        e1 = v1 && (f1.data[DATAW-1 -: 2] == THead);
        if (e0 && e1) begin
          a0 = !m_prio;
          a1 = m_prio;
        end else begin
          a0 = e0;
          a1 = e1;
        end
      end else if (m_lock == 0) begin
        a0 = v0;
      end else begin
        a1 = v1;
      end
    end
    check("iack_0", iack_0, a0);
    check("iack_1", iack_1, a1);
    if (rst) begin
      m_lock = -1; m_prio = 0; m_sel = 0; m_ovalid = 0; m_odata = '0; m_ovch = '0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_known = 1;
    end else begin
      m_ovalid = a0 | a1;
      if (a0 | a1) begin
        p = a1;
        f = p ? f1 : f0;
        t = f.data[DATAW-1 -: 2];
        m_odata = f.data; m_ovch = f.vch; m_sel = p;
        o.data = f.data; o.vch = f.vch; o.sel = p;
        exp_q.push_back(o);
        ack_cyc.push_back(cyc); ack_port.push_back(p); ack_type.push_back(t);
        if (p) void'(src1.pop_front());
        else void'(src0.pop_front());
        if (m_lock < 0) begin
          m_lock = int'(p);
          grant_q.push_back(p);
        end else if (t == TTail) begin
          m_lock = -1;
          m_prio = !p;
          m_cnt[p] = (m_cnt[p] + 1) % 65536;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    do_cycle(1'b1, 0);
    rst = 1'b0;
  endtask

  task automatic run_until_empty(input int rdy_pct, input int bub_pct, input int budget);
    int n = 0;
    while ((src0.size() > 0 || src1.size() > 0) && n < budget) begin
      do_cycle(int'($urandom_range(99)) < rdy_pct, bub_pct);
      n++;
    end
    if (src0.size() > 0 || src1.size() > 0) begin
      check("drain_timeout", 1, 0);
      src0.delete();
      src1.delete();
      do_reset();
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_ovalid"}, ovalid, 0);
    check({name, "_odata"}, odata, 0);
    check({name, "_ovch"}, ovch, 0);
    check({name, "_sel"}, sel, 0);
    check({name, "_cnt0"}, pkt_cnt_0, 0);
    check({name, "_cnt1"}, pkt_cnt_1, 0);
  endtask

  initial begin
    int    n, i_tail, j_head, cnt0;
    flit_t cp[$];
    rst = 1'b1; oready = 1'b0;
    ivalid_0 = 1'b0; ivalid_1 = 1'b0; idata_0 = '0; idata_1 = '0; ivch_0 = '0; ivch_1 = '0;
    m_known = 0;
    add_pkt(0, 1, -1);
    add_pkt(1, 1, -1);
    do_cycle(1'b1, 0);
    do_cycle(1'b1, 0);
    rst = 1'b0;
    src0.delete();
    src1.delete();
    check_zero("reset");

    // Single port burst: 22 back-to-back flits, then the tie goes to port 0.
    clear_log();
    add_pkt(1, 20, -1);
    n = cyc;
    run_until_empty(100, 0, 100);
    check("p1_burst_cycles", cyc - n, 22);
    check("p1_sel", sel, 1);
    check("p1_pkt_cnt", pkt_cnt_1, 1);
    clear_log();
    add_pkt(0, 1, -1);
    add_pkt(1, 1, -1);
    run_until_empty(100, 0, 50);
    check("prio_after_p1", grant_q[0], 0);

    // Simultaneous packets after reset: grants alternate starting at port 0.
    do_reset();
    clear_log();
    for (int k = 0; k < 10; k++) begin
      add_pkt(0, $urandom_range(3), -1);
      add_pkt(1, $urandom_range(3), -1);
    end
    run_until_empty(100, 0, 400);
    check("alt_grants", grant_q.size(), 20);
    for (int k = 0; k < grant_q.size(); k++) check("alt_grant_port", grant_q[k], k % 2);
    check("alt_cnt0", pkt_cnt_0, 10);
    check("alt_cnt1", pkt_cnt_1, 10);

    // Backpressure mid-packet.
    clear_log();
    add_pkt(0, 8, -1);
    cp = src0;
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b0, 0);
      check("stall_ovalid", ovalid, 0);
      check("stall_odata", odata, cp[2].data);
    end
    run_until_empty(100, 0, 50);
    check("stall_flit_count", ack_port.size(), 10);

    // Interleave attempt: port 1 HEAD waits until the cycle after port 0's TAIL.
    clear_log();
    add_pkt(0, 6, -1);
    add_pkt(1, 2, -1);
    start1 = cyc + 2;
    run_until_empty(100, 0, 50);
    start1 = 0;
    i_tail = -1;
    j_head = -1;
    for (int k = 0; k < ack_port.size(); k++) begin
      if (ack_port[k] == 0 && ack_type[k] == TTail && i_tail < 0) i_tail = k;
      if (ack_port[k] == 1 && j_head < 0) j_head = k;
    end
    check("interleave_order", (i_tail >= 0 && j_head == i_tail + 1), 1);
    if (i_tail >= 0 && j_head >= 0) check("interleave_gap", ack_cyc[j_head] - ack_cyc[i_tail], 1);

    // Stray DATA in idle is never acked; mid-packet HEAD is payload.
    clear_log();
    payload_seq++;
    src1.push_back(flit_t'({TData, PW'(payload_seq), VCHW'(1)}));
    for (int k = 0; k < 4; k++) do_cycle(1'b1, 0);
    check("stray_no_ack", ack_port.size(), 0);
    src1.delete();
    cnt0 = int'(pkt_cnt_0);
    clear_log();
    add_pkt(0, 5, 3);
    start1 = cyc + 1;
    add_pkt(1, 1, -1);
    run_until_empty(100, 0, 50);
    start1 = 0;
    for (int k = 0; k < 7; k++) check("mid_head_port", ack_port[k], 0);
    check("mid_head_cnt", pkt_cnt_0, 16'(cnt0 + 1));

    // Reset after five flits of a port 0 packet.
    clear_log();
    add_pkt(0, 10, -1);
    n = 0;
    while (ack_port.size() < 5 && n < 20) begin
      do_cycle(1'b1, 0);
      n++;
    end
    do_reset();
    src0.delete();
    check_zero("midrst");
    clear_log();
    add_pkt(1, 2, -1);
    do_cycle(1'b1, 0);
    check("post_rst_ack", ack_port.size(), 1);
    run_until_empty(100, 0, 50);

    // Randomised traffic with bubbles and backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        add_pkt(0, $urandom_range(6), ($urandom_range(3) == 0) ? 1 : -1);
        add_pkt(1, $urandom_range(6), -1);
      end
      run_until_empty(70, 25, 3000);
    end

    for (int k = 0; k < 3; k++) do_cycle(1'b1, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
